// File: rtl/s2p_if.sv
// Serial-in / parallel-out handshake bundle: a serial bit stream with valid/ready on
// one side and a parallel word with valid/ready on the other.
interface s2p_if #(
    parameter int N = 8
);
    logic         ser_valid;
    logic         ser_data;
    logic         ser_ready;
    logic [N-1:0] par_data;
    logic         par_valid;
    logic         par_ready;

    // master: the environment that drives serial bits and consumes parallel words
    modport master (
        output ser_valid,
        output ser_data,
        output par_ready,
        input  ser_ready,
        input  par_data,
        input  par_valid
    );

    modport slave (
        input  ser_valid,
        input  ser_data,
        input  par_ready,
        output ser_ready,
        output par_data,
        output par_valid
    );
endinterface

// File: rtl/s2p.sv
// Serial-to-parallel converter: LSB-first bits are shifted into an N-bit register and
// each completed word is parked in a holding register until downstream takes it.
module s2p #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rstn,
    s2p_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [N-1:0]  shift_q;
    logic [N-1:0]  shift_d;
    logic [N-1:0]  hold_q;
    logic          last_bit;
    logic          ser_ready_w;
    logic          accept;

    // Stall only the bit that would complete a word while the previous one is still held;
    // the first N-1 bits of the next word keep flowing into the shift register.
    assign last_bit    = (cnt_q == CNT_LAST);
    assign ser_ready_w = !(last_bit && (state_q == FULL));
    assign accept      = bus.ser_valid && ser_ready_w;

    assign bus.ser_ready = ser_ready_w;
    assign bus.par_valid = (state_q == FULL);
    assign bus.par_data  = hold_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (accept) begin
            shift_d = {bus.ser_data, shift_q[N-1:1]};
            cnt_d   = last_bit ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // A word can only complete in EMPTY, because the completing bit is refused while FULL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept && last_bit) begin
                        state_q <= FULL;
                        hold_q  <= shift_d;
                    end
                end
                FULL: begin
                    if (bus.par_ready) begin
                        state_q <= EMPTY;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_s2p.sv
// Scoreboard bench for s2p: a bit-queue reference model predicts words and readiness,
// and a negedge monitor compares every DUT output cycle against it.
module tb_s2p;
    localparam int N = 8;

    logic clk;
    logic rstn;

    s2p_if #(.N(N)) bus ();

    s2p #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accepted bits collect in a queue; N of them make a word.
    bit           mbits[$];
    logic [N-1:0] expq[$];
    bit           held = 1'b0;

    function automatic bit mdl_ready();
        return !(held && (mbits.size() == N - 1));
    endfunction

    always @(posedge clk) begin
        if (rstn) begin
            bit acc;
            logic [N-1:0] w;
            acc = bus.ser_valid && mdl_ready();
            if (held && bus.par_ready) held = 1'b0;
            if (acc) begin
                mbits.push_back(bus.ser_data);
                if (mbits.size() == N) begin
                    w = '0;
                    for (int i = 0; i < N; i++) w[i] = mbits[i];
                    expq.push_back(w);
                    mbits.delete();
                    held = 1'b1;
                end
            end
        end
    end

    always @(negedge rstn) begin
        mbits.delete();
        expq.delete();
        held = 1'b0;
    end

    // Monitor
    int           cyc = 0;
    int           pv_cyc[$];
    int           sr_low = 0;
    logic [N-1:0] last_word = '0;

    always @(negedge clk) begin
        if (rstn) begin
            cyc++;
            chk("ser_ready", 32'(bus.ser_ready), 32'(mdl_ready()));
            chk("par_valid", 32'(bus.par_valid), 32'(held));
            if (!bus.ser_ready) sr_low++;
            if (bus.par_valid) begin
                pv_cyc.push_back(cyc);
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL par_word: got %0h with no word expected at %0t", bus.par_data, $time);
                end else begin
                    chk("par_data", 32'(bus.par_data), 32'(expq[0]));
                    if (bus.par_ready) begin
                        last_word = bus.par_data;
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_bit(input bit b);
        bit acc;
        bus.ser_valid = 1'b1;
        bus.ser_data  = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = bus.ser_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_bit: got no ser_ready expected ser_ready within 200 cycles");
    endtask

    task automatic send_word(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        bus.ser_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] w;
        int c0;
        rstn          = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
        bus.par_ready = 1'b0;
        #3;
        chk("rst_ser_ready", 32'(bus.ser_ready), 32'd1);
        chk("rst_par_valid", 32'(bus.par_valid), 32'd0);
        chk("rst_par_data", 32'(bus.par_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Single word 0xA5
        bus.par_ready = 1'b1;
        pv_cyc.delete();
        send_word(8'hA5);
        c0 = cyc;
        idle(4);
        chk("a5_pulses", 32'(pv_cyc.size()), 32'd1);
        if (pv_cyc.size() > 0) chk("a5_latency", 32'(pv_cyc[0]), 32'(c0 + 1));
        chk("a5_word", 32'(last_word), 32'hA5);

        // Backpressure: 0x3C held, then 7 bits of 0xC3
        bus.par_ready = 1'b0;
        send_word(8'h3C);
        w = 8'hC3;
        for (int i = 0; i < N - 1; i++) send_bit(w[i]);
        bus.ser_valid = 1'b1;
        bus.ser_data  = w[N-1];
        @(negedge clk);
        chk("bp_ready_low", 32'(bus.ser_ready), 32'd0);
        chk("bp_hold", 32'(bus.par_data), 32'h3C);
        repeat (2) @(posedge clk);
        #1 bus.par_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_ready_back", 32'(bus.ser_ready), 32'd1);
        @(posedge clk);
        #1;
        idle(3);
        chk("bp_word", 32'(last_word), 32'hC3);

        // Gapped input 0x5A
        w = 8'h5A;
        for (int i = 0; i < N; i++) begin
            send_bit(w[i]);
            bus.ser_valid = 1'b0;
            bus.ser_data  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        idle(3);
        chk("gap_word", 32'(last_word), 32'h5A);

        // Reset mid-word with a held word pending
        bus.par_ready = 1'b0;
        send_word(8'hE7);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rstn = 1'b0;
        #2;
        chk("mid_rst_ser_ready", 32'(bus.ser_ready), 32'd1);
        chk("mid_rst_par_valid", 32'(bus.par_valid), 32'd0);
        chk("mid_rst_par_data", 32'(bus.par_data), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        bus.par_ready = 1'b1;
        send_word(8'h81);
        idle(3);
        chk("rst_word", 32'(last_word), 32'h81);

        // Back-to-back 0x01 then 0xFF
        pv_cyc.delete();
        sr_low = 0;
        send_word(8'h01);
        send_word(8'hFF);
        idle(3);
        chk("b2b_pulses", 32'(pv_cyc.size()), 32'd2);
        if (pv_cyc.size() == 2) chk("b2b_spacing", 32'(pv_cyc[1] - pv_cyc[0]), 32'd8);
        chk("b2b_ready_low", 32'(sr_low), 32'd0);
        chk("b2b_word", 32'(last_word), 32'hFF);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.ser_valid = ($urandom_range(3) != 0);
            bus.ser_data  = 1'($urandom);
            bus.par_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.par_ready = 1'b1;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/s2p.md
S2P -- requirements
Module: s2p

Interface
REQ-001 Parameter N, default 8: parallel word width in bits; legal range N >= 2.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 ser_valid  input  1  serial bit on ser_data is valid this cycle.
REQ-005 ser_data  input  1  serial data bit, LSB of the word first.
REQ-006 ser_ready  output  1  block can accept a serial bit this cycle.
REQ-007 par_data  output  N  assembled parallel word.
REQ-008 par_valid  output  1  par_data holds a complete word.
REQ-009 par_ready  input  1  downstream accepts par_data this cycle.

Function
REQ-010 The block SHALL transfer a serial bit only on a cycle where ser_valid && ser_ready; bits presented without ser_ready SHALL be ignored.
REQ-011 The block SHALL transfer a parallel word only on a cycle where par_valid && par_ready.
REQ-012 Each accepted bit SHALL shift into an N-bit shift register right-shift style: shift_reg <= {ser_data, shift_reg[N-1:1]}, so the first accepted bit ends in par_data[0].
REQ-013 A bit counter of width $clog2(N) SHALL count accepted bits 0..N-1, increment on each accepted bit, and wrap to 0 on the Nth accepted bit (word complete).
REQ-014 The output holding register SHALL have a 2-state FSM: EMPTY, FULL.
REQ-015 EMPTY -> FULL on word complete; holding register loads {ser_data, shift_reg[N-1:1]} in that same edge.
REQ-016 FULL -> EMPTY when par_ready is high; FULL -> FULL otherwise.
REQ-017 par_valid SHALL equal (state == FULL), registered-state driven; par_data SHALL be the holding register.
REQ-018 par_data SHALL remain stable while par_valid && !par_ready.
REQ-019 ser_ready SHALL be 0 exactly when count == N-1 and state == FULL, else 1; no combinational path from par_ready to ser_ready.
REQ-020 Consequently word complete SHALL occur only in EMPTY; the shift register SHALL keep collecting bits 0..N-2 of the next word while FULL.
REQ-021 Latency: par_valid SHALL rise on the clock edge that accepts the Nth bit (visible next cycle).
REQ-022 With par_ready held 1 and ser_valid held 1, throughput SHALL be one word per N cycles with ser_ready never deasserted.
REQ-023 Once par_ready drains FULL, ser_ready SHALL return to 1 in the following cycle.
REQ-024 Shift register and count SHALL hold value on cycles with no accepted bit.

Reset
REQ-025 On rstn low, asynchronously: state = EMPTY, count = 0, shift register = 0, holding register = 0.
REQ-026 During and immediately after reset: ser_ready = 1, par_valid = 0, par_data = 0.
REQ-027 Reset mid-word SHALL discard partial bits and any unread held word; the first bit accepted after release SHALL be bit 0 of a new word.

Verification
REQ-028 Reset: assert rstn=0 mid-operation -> ser_ready=1, par_valid=0, par_data=0 immediately, without a clock edge.
REQ-029 Single word: par_ready=1, ser_valid=1, bits 1,0,1,0,0,1,0,1 -> par_valid high for exactly one cycle after 8th bit, par_data=8'hA5.
REQ-030 Backpressure: par_ready=0, send 8'h3C then 7 bits of 8'hC3 -> ser_ready=0 with count=7, par_data stays 8'h3C; raise par_ready -> ser_ready=1 next cycle, 8th bit accepted, par_data=8'hC3.
REQ-031 Gapped input: ser_valid toggling 1/0 while sending 8'h5A -> only valid cycles shift; par_data=8'h5A after 8 accepted bits.
REQ-032 Reset mid-word: 4 bits accepted, rstn pulsed low, then 8 bits of 8'h81 -> par_data=8'h81, no residue of earlier bits.
REQ-033 Back-to-back: par_ready=1, continuous 8'h01 then 8'hFF -> par_valid pulses exactly 8 cycles apart, ser_ready constantly 1.
